// File: rtl/exec_unit.sv
// exec_unit: multi-cycle RV32I/RV32M register-register execution unit with valid/ready handshake.
// Define EXEC_UNIT_RVM_EN to build the bit-serial multiply/divide (M-extension) datapath.
module exec_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            negative,
    output logic            zero,
    output logic            illegal
);
    localparam int unsigned SAW  = $clog2(XLEN);
    localparam int unsigned CW   = SAW + 1;  // wide enough to hold SHIFT_STEP == XLEN
    localparam int unsigned CNTW = SAW;

    typedef enum logic [1:0] {IDLE, SHIFT, MULDIV, DONE} state_e;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            ill_q, ill_d;
    logic            in_rdy_q, out_vld_q, neg_q, zero_q;
    logic [XLEN-1:0] sh_val_q, sh_val_d, sh_next;
    logic [CW-1:0]   sh_rem_q, sh_rem_d, sh_step;
    shkind_e         sh_kind_q, sh_kind_d;
    logic [SAW-1:0]  shamt;
    logic            is_base, is_alt;

    assign shamt   = in2[SAW-1:0];
    assign is_base = (funct7 == 7'b0000000);
    assign is_alt  = (funct7 == 7'b0100000);

`ifdef EXEC_UNIT_RVM_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0]   md_hi_q, md_hi_d, md_lo_q, md_lo_d, md_op_q, md_op_d;
    logic [2:0]        md_f3_q, md_f3_d;
    logic              md_neg_q, md_neg_d, md_rneg_q, md_rneg_d;
    logic [CNTW-1:0]   md_cnt_q, md_cnt_d;
    logic              is_m, a_neg, b_neg, div_sgn, div_ge;
    logic [XLEN:0]     mul_sum, div_rs;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   md_fin;

    assign is_m = (funct7 == 7'b0000001);
`endif

    // Next-state, datapath and result selection.
    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        ill_d     = ill_q;
        sh_val_d  = sh_val_q;
        sh_rem_d  = sh_rem_q;
        sh_kind_d = sh_kind_q;
        sh_step   = '0;
        sh_next   = sh_val_q;
`ifdef EXEC_UNIT_RVM_EN
        md_hi_d   = md_hi_q;
        md_lo_d   = md_lo_q;
        md_op_d   = md_op_q;
        md_f3_d   = md_f3_q;
        md_neg_d  = md_neg_q;
        md_rneg_d = md_rneg_q;
        md_cnt_d  = md_cnt_q;
        a_neg     = 1'b0;
        b_neg     = 1'b0;
        div_sgn   = 1'b0;
        div_ge    = 1'b0;
        mul_sum   = '0;
        div_rs    = '0;
        prod      = '0;
        md_fin    = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ill_d   = 1'b0;
                    res_d   = '0;
                    state_d = DONE;
                    if (is_base) begin
                        unique case (funct3)
                            3'b000: res_d = in1 + in2;
                            3'b010: res_d = XLEN'($signed(in1) < $signed(in2));
                            3'b011: res_d = XLEN'(in1 < in2);
                            3'b100: res_d = in1 ^ in2;
                            3'b110: res_d = in1 | in2;
                            3'b111: res_d = in1 & in2;
                            default: begin
                                res_d     = in1;
                                sh_val_d  = in1;
                                sh_rem_d  = CW'(shamt);
                                sh_kind_d = funct3[2] ? SH_RL : SH_LL;
                                if (shamt != '0) state_d = SHIFT;
                            end
                        endcase
                    end else if (is_alt && funct3 == 3'b000) begin
                        res_d = in1 - in2;
                    end else if (is_alt && funct3 == 3'b101) begin
                        res_d     = in1;
                        sh_val_d  = in1;
                        sh_rem_d  = CW'(shamt);
                        sh_kind_d = SH_RA;
                        if (shamt != '0) state_d = SHIFT;
`ifdef EXEC_UNIT_RVM_EN
                    end else if (is_m) begin
                        md_f3_d  = funct3;
                        md_cnt_d = '0;
                        md_hi_d  = '0;
                        if (!funct3[2]) begin
                            // Multiply magnitudes, restore the sign at the end.
                            a_neg     = (funct3 == 3'b001 || funct3 == 3'b010) && in1[XLEN-1];
                            b_neg     = (funct3 == 3'b001) && in2[XLEN-1];
                            md_op_d   = a_neg ? -in1 : in1;
                            md_lo_d   = b_neg ? -in2 : in2;
                            md_neg_d  = a_neg ^ b_neg;
                            md_rneg_d = 1'b0;
                            state_d   = MULDIV;
                        end else begin
                            div_sgn = !funct3[0];
                            if (in2 == '0) begin
                                res_d = funct3[1] ? in1 : '1;
                            end else if (div_sgn && in1 == MOST_NEG && in2 == '1) begin
                                res_d = funct3[1] ? '0 : MOST_NEG;
                            end else begin
                                a_neg     = div_sgn && in1[XLEN-1];
                                b_neg     = div_sgn && in2[XLEN-1];
                                md_lo_d   = a_neg ? -in1 : in1;
                                md_op_d   = b_neg ? -in2 : in2;
                                md_neg_d  = a_neg ^ b_neg;
                                md_rneg_d = a_neg;
                                state_d   = MULDIV;
                            end
                        end
`endif
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                sh_step = (sh_rem_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : sh_rem_q;
                unique case (sh_kind_q)
                    SH_LL:   sh_next = sh_val_q << sh_step;
                    SH_RL:   sh_next = sh_val_q >> sh_step;
                    default: sh_next = $unsigned($signed(sh_val_q) >>> sh_step);
                endcase
                sh_val_d = sh_next;
                sh_rem_d = sh_rem_q - sh_step;
                if (sh_rem_q == sh_step) begin
                    res_d   = sh_next;
                    state_d = DONE;
                end
            end
`ifdef EXEC_UNIT_RVM_EN
            MULDIV: begin
                md_cnt_d = md_cnt_q + CNTW'(1);
                if (!md_f3_q[2]) begin
                    // Shift-add: {hi,lo} accumulates the product as the multiplier shifts out.
                    mul_sum = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_op_q} : '0);
                    md_hi_d = mul_sum[XLEN:1];
                    md_lo_d = {mul_sum[0], md_lo_q[XLEN-1:1]};
                    prod    = {md_hi_d, md_lo_d};
                    if (md_neg_q) prod = -prod;
                    md_fin  = (md_f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                end else begin
                    // Restoring division: hi is the partial remainder, lo collects quotient bits.
                    div_rs  = {md_hi_q, md_lo_q[XLEN-1]};
                    div_ge  = (div_rs >= {1'b0, md_op_q});
                    md_hi_d = div_ge ? XLEN'(div_rs - {1'b0, md_op_q}) : div_rs[XLEN-1:0];
                    md_lo_d = {md_lo_q[XLEN-2:0], div_ge};
                    if (md_f3_q[1]) md_fin = md_rneg_q ? -md_hi_d : md_hi_d;
                    else            md_fin = md_neg_q  ? -md_lo_d : md_lo_d;
                end
                if (md_cnt_q == CNTW'(XLEN-1)) begin
                    res_d   = md_fin;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            res_q     <= '0;
            ill_q     <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b0;
            sh_val_q  <= '0;
            sh_rem_q  <= '0;
            sh_kind_q <= SH_LL;
`ifdef EXEC_UNIT_RVM_EN
            md_hi_q   <= '0;
            md_lo_q   <= '0;
            md_op_q   <= '0;
            md_f3_q   <= '0;
            md_neg_q  <= 1'b0;
            md_rneg_q <= 1'b0;
            md_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            ill_q     <= ill_d;
            in_rdy_q  <= (state_d == IDLE);
            out_vld_q <= (state_d == DONE);
            neg_q     <= res_d[XLEN-1];
            zero_q    <= (res_d == '0);
            sh_val_q  <= sh_val_d;
            sh_rem_q  <= sh_rem_d;
            sh_kind_q <= sh_kind_d;
`ifdef EXEC_UNIT_RVM_EN
            md_hi_q   <= md_hi_d;
            md_lo_q   <= md_lo_d;
            md_op_q   <= md_op_d;
            md_f3_q   <= md_f3_d;
            md_neg_q  <= md_neg_d;
            md_rneg_q <= md_rneg_d;
            md_cnt_q  <= md_cnt_d;
`endif
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign result    = res_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised multi-cycle integer execution unit for the R4 core, superseding the purely combinational `alu`. Accepts one RV32I/RV32M register-register operation through a valid/ready handshake. Executes logic/add/compare ops in one cycle, shifts iteratively, and multiply/divide bit-serially. Holds the registered result with `negative`/`zero` flags until the consumer takes it.

## Interface
- `XLEN`, 32: operand/result width; power of two, ≥ 8.
- `SHIFT_STEP`, 1: bit positions shifted per cycle; power of two, 1..`XLEN`.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `in1`, `in2`  in  `XLEN`  operands (rs1, rs2).
- `funct3`  in  3  RISC-V funct3.
- `funct7`  in  7  RISC-V funct7.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  `XLEN`  registered result.
- `negative`  out  1  registered `result[XLEN-1]`.
- `zero`  out  1  registered `result == 0`.
- `illegal`  out  1  operation was an unsupported encoding.

## Operation
- Accept on `in_valid && in_ready`; operands and function are latched; inputs are then don't-care.
- funct7 `0000000`, by funct3:
  - 000 add, 001 sll, 010 slt (signed), 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
- funct7 `0100000`: funct3 000 sub, 101 sra.
- funct7 `0000001`, by funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- Any other funct7/funct3 combination: `illegal`=1, `result`=0, flags computed from 0.
- Arithmetic is modulo 2^`XLEN`; slt/sltu produce 0 or 1.
- Shift amount is `in2[$clog2(XLEN)-1:0]`; upper bits are ignored.
- Division by zero: quotient all-ones, remainder = dividend.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder 0.
- States and transitions:
  - IDLE: accept → SHIFT (shift with nonzero amount), MULDIV (M op that is not a special case), else DONE.
  - SHIFT: shift by min(`SHIFT_STEP`, remaining) per cycle → DONE when remaining = 0.
  - MULDIV: one bit per cycle for `XLEN` cycles → DONE.
  - DONE: `out_valid`=1; `result`/flags/`illegal` stable; on `out_ready` → IDLE.

## Timing
- Reset: state IDLE; `in_ready`=1; `out_valid`, `result`, `negative`, `zero`, `illegal` all 0.
- Reset mid-operation abandons the operation without producing a result.
- Latency, accept edge to `out_valid` high:
  - single-cycle ops, illegal ops, shift by 0, div special cases: 1 cycle.
  - shifts: 1 + ceil(shamt/`SHIFT_STEP`) cycles.
  - mul/div: `XLEN`+1 cycles.
- `out_valid` remains high until accepted by `out_ready`; the result may be held indefinitely.
- `in_ready` goes low the cycle after accept and returns high the cycle after `out_valid && out_ready`.
- No overlap of operations; maximum throughput is one operation per 2 cycles.

## Configuration
- `EXEC_UNIT_RVM_EN`:
  - Defined: the M-extension datapath (MULDIV state, multiplier/divider registers) is built.
  - Undefined: funct7 `0000001` is treated as illegal (`illegal`=1, `result`=0, latency 1), and no MULDIV logic is synthesised.

## Test plan
- Add wrap: `in1`=FFFFFFFF, `in2`=1, add → after 1 cycle `result`=0, `zero`=1, `negative`=0.
- Sub: 0 − 1 → `result`=FFFFFFFF, `negative`=1; with `out_ready` held low for 5 cycles, `result` stays constant and `in_ready` stays 0.
- sra with `SHIFT_STEP`=4: `in1`=80000000, `in2`=0000003F (shamt 31) → `result`=FFFFFFFF after 9 cycles; same operands with srl → `result`=00000001.
- Illegal: funct7=0100000, funct3=111 → `illegal`=1, `result`=0, `zero`=1, latency 1.
- With `EXEC_UNIT_RVM_EN`: div 80000000 / FFFFFFFF → 80000000 in 1 cycle; divu 7 / 0 → FFFFFFFF; mulh FFFFFFFF × FFFFFFFF → 0 after 33 cycles.
- Reset at cycle 10 of a mul → next cycle IDLE with all outputs 0; next add 2+3 → `result`=5.
